// File: rtl/mac_vec_engine.sv
// mac_vec_engine: LANES-wide packed dot-product engine that accumulates BEATS beats.
// Latency: result, overflow flag, result-valid pulse and IRQ update 3 edges after the last accepted beat.
// Backpressure: MAC_READY is high only in ACCUM, so a source must hold its beat until ready is seen.
// Ports: clk/reset (async, active-high); MAC_INA/MAC_INB packed lane operands with MAC_VALID/MAC_READY;
//        MAC_CTRL {EN, SIGNED, SAT, BEATS-1, START}; IRQ_CLR; MAC_OUT/MAC_OVF held results with
//        MAC_OUT_VALID pulse; MAC_BUSY (not IDLE); IRQ_MAC sticky completion flag.
module mac_vec_engine #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*LANE_W-1:0] MAC_INA,
  input  logic [LANES*LANE_W-1:0] MAC_INB,
  input  logic                    MAC_VALID,
  output logic                    MAC_READY,
  input  logic [7:0]              MAC_CTRL,
  input  logic                    IRQ_CLR,
  output logic [OUT_W-1:0]        MAC_OUT,
  output logic                    MAC_OUT_VALID,
  output logic                    MAC_OVF,
  output logic                    MAC_BUSY,
  output logic                    IRQ_MAC
);

  localparam int PW = 2 * LANE_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      signed_q, sat_q;
  logic [3:0]                beats_m1_q, cnt_q;
  logic [LANES*LANE_W-1:0]   a0_q, b0_q;
  logic                      v0_q, v1_q;
  logic [LANES-1:0][PW-1:0]  prod_q, prod_d;
  logic [ACC_W-1:0]          acc_q, lane_sum;
  logic [OUT_W-1:0]          out_q, shaped;
  logic                      ovf_q, out_vld_q, irq_q, irq_d;
  logic [PW-1:0]             a_ext, b_ext;
  logic                      fits, ovf;

  logic en, start, accept, start_go, done_go, abort;

  assign en    = MAC_CTRL[7];
  assign start = MAC_CTRL[0];

  // Control decode: only EN is honoured once the engine has left IDLE.
  always_comb begin
    state_d   = state_q;
    MAC_READY = 1'b0;
    start_go  = 1'b0;
    done_go   = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && start) begin
          start_go = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        MAC_READY = 1'b1;
        if (!en) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (MAC_VALID && cnt_q == beats_m1_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!en) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (!v0_q && !v1_q) begin
          // Pipeline empty: the accumulator is final, publish it on this edge.
          done_go = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = MAC_VALID && MAC_READY;

  // Modular product of width-extended operands gives the correct low PW bits
  // for both signed and unsigned operands.
  always_comb begin
    prod_d = '0;
    a_ext  = '0;
    b_ext  = '0;
    for (int i = 0; i < LANES; i++) begin
      a_ext = {{LANE_W{signed_q & a0_q[i*LANE_W+LANE_W-1]}}, a0_q[i*LANE_W +: LANE_W]};
      b_ext = {{LANE_W{signed_q & b0_q[i*LANE_W+LANE_W-1]}}, b0_q[i*LANE_W +: LANE_W]};
      prod_d[i] = a_ext * b_ext;
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(ACC_W-PW){signed_q & prod_q[i][PW-1]}}, prod_q[i]};
    end
  end

  // The accumulator fits OUT_W when its discarded upper bits are a pure
  // sign extension (signed) or zero extension (unsigned).
  always_comb begin
    if (signed_q) begin
      fits = (&acc_q[ACC_W-1:OUT_W-1]) | ~(|acc_q[ACC_W-1:OUT_W-1]);
    end else begin
      fits = ~(|acc_q[ACC_W-1:OUT_W]);
    end
    shaped = acc_q[OUT_W-1:0];
    if (sat_q && !fits) begin
      if (signed_q) begin
        shaped = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        shaped = '1;
      end
    end
    ovf = ~fits;
  end

  // Set beats clear on a simultaneous IRQ_CLR; a new run clears the flag.
  always_comb begin
    irq_d = irq_q;
    if (start_go || IRQ_CLR) irq_d = 1'b0;
    if (done_go)             irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      signed_q   <= 1'b0;
      sat_q      <= 1'b0;
      beats_m1_q <= '0;
      cnt_q      <= '0;
      a0_q       <= '0;
      b0_q       <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      out_vld_q <= done_go;
      if (start_go) begin
        signed_q   <= MAC_CTRL[6];
        sat_q      <= MAC_CTRL[5];
        beats_m1_q <= MAC_CTRL[4:1];
        cnt_q      <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (accept) begin
        a0_q <= MAC_INA;
        b0_q <= MAC_INB;
      end
      // An abort flushes in-flight beats; the accumulator is cleared at the next start.
      v0_q <= accept && !abort;
      v1_q <= v0_q && !abort;
      if (v0_q) prod_q <= prod_d;
      if (start_go) begin
        acc_q <= '0;
      end else if (v1_q && !abort) begin
        acc_q <= acc_q + lane_sum;
      end
      if (done_go) begin
        out_q <= shaped;
        ovf_q <= ovf;
      end
    end
  end

  assign MAC_OUT       = out_q;
  assign MAC_OVF       = ovf_q;
  assign MAC_OUT_VALID = out_vld_q;
  assign MAC_BUSY      = (state_q != IDLE);
  assign IRQ_MAC       = irq_q;

endmodule

// File: tb/tb_mac_vec_engine.sv
// Testbench for mac_vec_engine: directed runs, expected results queued by stimulus,
// checked by an independent monitor on every MAC_OUT_VALID pulse.
module tb_mac_vec_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MAC_INA, MAC_INB;
  logic        MAC_VALID, MAC_READY;
  logic [7:0]  MAC_CTRL;
  logic        IRQ_CLR;
  logic [15:0] MAC_OUT;
  logic        MAC_OUT_VALID, MAC_OVF, MAC_BUSY, IRQ_MAC;

  typedef struct packed {
    logic [15:0] out;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  mac_vec_engine #(.LANES(4), .LANE_W(8), .ACC_W(32), .OUT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .MAC_INA       (MAC_INA),
    .MAC_INB       (MAC_INB),
    .MAC_VALID     (MAC_VALID),
    .MAC_READY     (MAC_READY),
    .MAC_CTRL      (MAC_CTRL),
    .IRQ_CLR       (IRQ_CLR),
    .MAC_OUT       (MAC_OUT),
    .MAC_OUT_VALID (MAC_OUT_VALID),
    .MAC_OVF       (MAC_OVF),
    .MAC_BUSY      (MAC_BUSY),
    .IRQ_MAC       (IRQ_MAC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] o, input logic v);
    exp_t e;
    e.out = o;
    e.ovf = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic sg, input logic sat, input int beats);
    logic [3:0] bm1;
    bm1 = 4'(beats - 1);
    MAC_CTRL = {1'b1, sg, sat, bm1, 1'b1};
    tick();
    MAC_CTRL = 8'h80;
    chk("busy_after_start", MAC_BUSY, 1);
  endtask

  // Holds the beat until the engine takes it; returns 1ns after the accepting edge.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    logic got;
    got = 1'b0;
    MAC_INA = a;
    MAC_INB = b;
    MAC_VALID = 1'b1;
    for (int t = 0; t < 64 && !got; t++) begin
      rdy = MAC_READY;
      tick();
      if (rdy) got = 1'b1;
    end
    MAC_VALID = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_accept: got no ready in 64 cycles, expected ready");
    end
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      if (!MAC_BUSY) idle = 1'b1;
      else tick();
    end
    if (!idle) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: got busy after 100 cycles, expected idle");
    end
    tick();
  endtask

  task automatic run(input logic sg, input logic sat, input int beats,
                     input logic [31:0] a, input logic [31:0] b);
    start_run(sg, sat, beats);
    for (int i = 0; i < beats; i++) send_beat(a, b);
    wait_idle();
  endtask

  // Monitor: every result pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && MAC_OUT_VALID) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got MAC_OUT=0x%0h with no queued result, expected none", MAC_OUT);
        end else begin
          e = exp_q.pop_front();
          chk("mac_out", MAC_OUT, e.out);
          chk("mac_ovf", MAC_OVF, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected finish");
    $fatal(1);
  end

  initial begin
    int acc_cnt;
    reset = 1'b1;
    MAC_INA = '0;
    MAC_INB = '0;
    MAC_VALID = 1'b0;
    MAC_CTRL = 8'h00;
    IRQ_CLR = 1'b0;
    repeat (3) tick();
    chk("rst_out", MAC_OUT, 0);
    chk("rst_ovf", MAC_OVF, 0);
    chk("rst_busy", MAC_BUSY, 0);
    chk("rst_ready", MAC_READY, 0);
    chk("rst_irq", IRQ_MAC, 0);
    chk("rst_outvld", MAC_OUT_VALID, 0);
    reset = 1'b0;
    tick();

    // 1: unsigned single beat, 5+12+21+32 = 70; IRQ exactly 3 edges after accept.
    start_run(1'b0, 1'b0, 1);
    push_exp(16'h0046, 1'b0);
    send_beat(32'h01020304, 32'h05060708);
    chk("t1_irq_k0", IRQ_MAC, 0);
    tick();
    tick();
    chk("t1_irq_k2", IRQ_MAC, 0);
    tick();
    chk("t1_irq_k3", IRQ_MAC, 1);
    chk("t1_outvld_k3", MAC_OUT_VALID, 1);
    wait_idle();
    chk("t1_out_held", MAC_OUT, 16'h0046);

    // 2: signed, four lanes of -1*2 -> -8.
    push_exp(16'hFFF8, 1'b0);
    run(1'b1, 1'b0, 1, 32'hFFFFFFFF, 32'h02020202);

    // 3: unsigned 16 beats of 4*255*255 = 0x3F8040.
    push_exp(16'hFFFF, 1'b1);
    run(1'b0, 1'b1, 16, 32'hFFFFFFFF, 32'hFFFFFFFF);
    push_exp(16'h8040, 1'b1);
    run(1'b0, 1'b0, 16, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // 4: signed, lane0 only 127*127 per beat, 4 beats = 64516 = 0xFC04; VALID toggled.
    for (int m = 0; m < 2; m++) begin
      push_exp(m == 0 ? 16'hFC04 : 16'h7FFF, 1'b1);
      start_run(1'b1, m[0], 4);
      MAC_INA = 32'h0000007F;
      MAC_INB = 32'h0000007F;
      acc_cnt = 0;
      for (int i = 0; i < 12; i++) begin
        MAC_VALID = (i % 2 == 0);
        if (MAC_VALID && MAC_READY) acc_cnt++;
        tick();
      end
      MAC_VALID = 1'b0;
      chk("t4_accepts", acc_cnt, 4);
      wait_idle();
    end

    // 5: abort after 2 of 4 beats; old result and IRQ untouched, no stale sum afterwards.
    start_run(1'b0, 1'b0, 4);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF);
    MAC_CTRL = 8'h00;
    tick();
    chk("t5_busy_abort", MAC_BUSY, 0);
    repeat (8) tick();
    chk("t5_irq", IRQ_MAC, 0);
    chk("t5_out_kept", MAC_OUT, 16'h7FFF);
    chk("t5_ovf_kept", MAC_OVF, 1);
    push_exp(16'h0046, 1'b0);
    run(1'b0, 1'b0, 1, 32'h01020304, 32'h05060708);

    // 6: START during DRAIN ignored; IRQ_CLR on the completion edge loses to set.
    start_run(1'b0, 1'b0, 1);
    push_exp(16'h0046, 1'b0);
    send_beat(32'h01020304, 32'h05060708);
    MAC_CTRL = 8'hFF;
    tick();
    MAC_CTRL = 8'h80;
    tick();
    IRQ_CLR = 1'b1;
    tick();
    chk("t6_irq_set_wins", IRQ_MAC, 1);
    chk("t6_busy_done", MAC_BUSY, 1);
    tick();
    chk("t6_irq_cleared", IRQ_MAC, 0);
    chk("t6_no_restart", MAC_BUSY, 0);
    IRQ_CLR = 1'b0;
    tick();

    // Reset in the middle of ACCUM.
    start_run(1'b1, 1'b1, 4);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF);
    reset = 1'b1;
    #2;
    chk("mrst_out", MAC_OUT, 0);
    chk("mrst_ovf", MAC_OVF, 0);
    chk("mrst_busy", MAC_BUSY, 0);
    chk("mrst_ready", MAC_READY, 0);
    chk("mrst_irq", IRQ_MAC, 0);
    MAC_CTRL = 8'h00;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("mrst_irq_after", IRQ_MAC, 0);
    chk("sb_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
